// File: rtl/spi_reg_pkg.sv
// Shared constants and types for the SPI register controller.
package spi_reg_pkg;
  localparam int FRAME_BITS = 16;
  localparam int NUM_REGS   = 5;

  localparam int ADDR_EN_OUT_LO = 0;
  localparam int ADDR_EN_OUT_HI = 1;
  localparam int ADDR_EN_PWM_LO = 2;
  localparam int ADDR_EN_PWM_HI = 3;
  localparam int ADDR_PWM_DUTY  = 4;

  // The bit counter stops one past a full frame, so over-long frames stay distinguishable.
  localparam logic [4:0] CNT_MAX = 5'(FRAME_BITS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
endpackage

// File: rtl/spi_reg_ctrl_sync_edge.sv
// N-flop synchroniser with history flop and registered rise/fall pulses.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] chain;
  logic              hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{RST_VAL}};
      hist  <= RST_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      hist  <= chain[STAGES-1];
      rise  <= chain[STAGES-1] & ~hist;
      fall  <= ~chain[STAGES-1] & hist;
    end
  end

  // hist holds the level that the current pulse describes.
  assign level = hist;
endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI-slave write-only register bank: 16-bit frames {rw, addr[6:0], data[7:0]}.
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       frame_err
);
  logic ncs_lvl, ncs_rise, ncs_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic copi_lvl, copi_rise, copi_fall;
  logic unused_sync;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs (
    .clk(clk), .rst(rst), .din(ncs), .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .din(sclk), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_copi (
    .clk(clk), .rst(rst), .din(copi), .level(copi_lvl), .rise(copi_rise), .fall(copi_fall)
  );

  assign unused_sync = ^{sclk_lvl, sclk_fall, copi_rise, copi_fall};

  state_t                  state;
  logic [FRAME_BITS-1:0]   shreg;
  logic [4:0]              cnt;
  logic                    wr_pend;
  logic                    fall_pend;
  logic [7:0]              regs [NUM_REGS];
  logic                    frame_ok;

  assign frame_ok = (cnt == 5'(FRAME_BITS)) && shreg[15] && (shreg[14:8] <= MAX_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      wr_pend   <= 1'b0;
      fall_pend <= 1'b0;
      frame_err <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
    end else begin
      // A chip-select fall outside IDLE is remembered so IDLE can still act on it.
      if (ncs_fall && state != IDLE) fall_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (ncs_fall || fall_pend) begin
            shreg     <= '0;
            cnt       <= '0;
            fall_pend <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (ncs_rise) begin
            frame_err <= ~frame_ok;
            wr_pend   <= frame_ok;
            state     <= COMMIT;
          end else if (sclk_rise && !ncs_lvl) begin
            shreg <= {shreg[FRAME_BITS-2:0], copi_lvl};
            if (cnt != CNT_MAX) cnt <= cnt + 5'd1;
          end
        end
        COMMIT: begin
          if (wr_pend) begin
            for (int i = 0; i < NUM_REGS; i++)
              if (shreg[14:8] == 7'(i)) regs[i] <= shreg[7:0];
          end
          frame_err <= 1'b0;
          wr_pend   <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign en_reg_out_7_0  = regs[ADDR_EN_OUT_LO];
  assign en_reg_out_15_8 = regs[ADDR_EN_OUT_HI];
  assign en_reg_pwm_7_0  = regs[ADDR_EN_PWM_LO];
  assign en_reg_pwm_15_8 = regs[ADDR_EN_PWM_HI];
  assign pwm_duty_cycle  = regs[ADDR_PWM_DUTY];
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed and randomized SPI frames checked against a register-bank model.
module tb_spi_reg_ctrl;
  logic       clk = 1'b0;
  logic       rst, sclk, copi, ncs;
  logic [7:0] r0, r1, r2, r3, r4;
  logic       frame_err;

  spi_reg_ctrl dut (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
    .en_reg_out_7_0(r0), .en_reg_out_15_8(r1), .en_reg_pwm_7_0(r2),
    .en_reg_pwm_15_8(r3), .pwm_duty_cycle(r4), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [7:0] mreg [5];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] dut_reg(input int i);
    case (i)
      0:       return r0;
      1:       return r1;
      2:       return r2;
      3:       return r3;
      default: return r4;
    endcase
  endfunction

  task automatic chk_regs(input string tag);
    for (int i = 0; i < 5; i++) chk($sformatf("%s reg%0d", tag, i), dut_reg(i), mreg[i]);
  endtask

  task automatic chk_err(input string tag, input logic exp);
    chk(tag, {7'b0, frame_err}, {7'b0, exp});
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    copi = b;
    ticks(3);
    sclk = 1'b1;
    ticks(3);
    sclk = 1'b0;
  endtask

  // Sends the low nbits of v MSB first, then checks the commit window cycle by cycle.
  task automatic send_frame(input string tag, input logic [16:0] v, input int nbits);
    logic ok;
    logic [6:0] a;
    a  = v[14:8];
    ok = (nbits == 16) && v[15] && (a <= 7'd4);
    ncs = 1'b0;
    ticks(3);
    for (int i = nbits - 1; i >= 0; i--) send_bit(v[i]);
    ticks(3);
    ncs = 1'b1;
    ticks(3);
    chk_err({tag, " err_early"}, 1'b0);
    ticks(1);
    chk_err({tag, " err_pulse"}, ~ok);
    chk_regs({tag, " before"});
    if (ok) mreg[a] = v[7:0];
    ticks(1);
    chk_err({tag, " err_after"}, 1'b0);
    chk_regs({tag, " after"});
    ticks(1);
  endtask

  initial begin
    logic [16:0] v;
    int          nb;
    logic [15:0] f;
    for (int i = 0; i < 5; i++) mreg[i] = 8'h00;
    rst = 1'b1; ncs = 1'b1; sclk = 1'b0; copi = 1'b0;
    ticks(4);
    rst = 1'b0;
    ticks(2);
    chk_err("reset err", 1'b0);
    chk_regs("reset");

    send_frame("w8055", {1'b0, 16'h8055}, 16);
    send_frame("w84F0", {1'b0, 16'h84F0}, 16);
    send_frame("w83A5", {1'b0, 16'h83A5}, 16);
    send_frame("badaddr", {1'b0, 16'h8A12}, 16);
    send_frame("read", {1'b0, 16'h0233}, 16);
    send_frame("short15", {1'b0, 16'h8177}, 15);
    send_frame("long17", {1'b1, 16'h8177}, 17);
    send_frame("w81C3", {1'b0, 16'h81C3}, 16);

    // Reset in the middle of a frame; the tail must never commit.
    f = 16'h80FF;
    ncs = 1'b0;
    ticks(3);
    for (int i = 15; i >= 8; i--) send_bit(f[i]);
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) mreg[i] = 8'h00;
    for (int i = 7; i >= 0; i--) send_bit(f[i]);
    ticks(3);
    ncs = 1'b1;
    ticks(8);
    chk_regs("midreset");
    send_frame("post_reset", {1'b0, 16'h8269}, 16);

    for (int k = 0; k < 30; k++) begin
      f[15]   = ($urandom_range(0, 3) != 0);
      f[14:8] = 7'($urandom_range(0, 10));
      f[7:0]  = 8'($urandom);
      case ($urandom_range(0, 7))
        0:       nb = 15;
        1:       nb = 17;
        default: nb = 16;
      endcase
      v = {1'($urandom), f};
      if (nb == 15) v = {2'b00, f[14:0]};
      send_frame($sformatf("rnd%0d", k), v, nb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
